prog_clock_divider: RTL and testbench
=====================================

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter WIDTH, default 16, bit width of divisor and phase counter.
REQ-002 Parameter DEFAULT_DIV, default 4, divisor in force after reset; SHALL be >= 2 and < 2^WIDTH.
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run request; sampled only in IDLE and at period end.
REQ-006 div_in  input  WIDTH  requested divisor N.
REQ-007 div_load  input  1  one-cycle strobe capturing div_in.
REQ-008 div_ack  output  1  one-cycle pulse: load accepted into pending register.
REQ-009 div_err  output  1  one-cycle pulse: load rejected (div_in < 2).
REQ-010 clk_out  output  1  registered divided clock.
REQ-011 rise_tick  output  1  high exactly in cycles where clk_out went 0->1.
REQ-012 fall_tick  output  1  high exactly in cycles where clk_out went 1->0.
REQ-013 cur_div  output  WIDTH  divisor currently in force.

Function
REQ-014 FSM states IDLE, RUN; phase counter cnt counts 0..N-1 in RUN.
REQ-015 High phase H = ceil(N/2) cycles, low phase N-H cycles; period exactly N clk_in cycles; N=2 -> 1/1, N=3 -> 2/1, N=4 -> 2/2.
REQ-016 IDLE: clk_out=0, cnt=0, no ticks; if en=1 then next edge: state RUN, cnt=0, clk_out=1, rise_tick=1 (one-cycle start latency).
REQ-017 RUN, cnt != N-1: cnt <= cnt+1, clk_out <= (cnt+1 < H); fall_tick=1 when that drops clk_out.
REQ-018 RUN, cnt == N-1 (period end): pending divisor, if any, becomes cur_div; cnt <= 0; if en=1 clk_out <= 1 and rise_tick=1, else state IDLE with clk_out held 0.
REQ-019 en deassertion mid-period SHALL NOT truncate the period; no runt pulse on clk_out ever.
REQ-020 div_load with div_in >= 2: pending <= div_in, pending_valid set, div_ack pulses next cycle.
REQ-021 div_load with div_in < 2: pending unchanged, div_err pulses next cycle, no div_ack.
REQ-022 Second valid load before period end overwrites pending; last one wins; each load acked.
REQ-023 Valid load in IDLE applies to cur_div on the next edge (no period to finish).
REQ-024 Load coinciding with period end: new value goes to pending, applies at the following period end; old pending applies now.
REQ-025 Load coinciding with IDLE->RUN start: first period uses prior cur_div; new value applies at its end.
REQ-026 cnt and comparisons SHALL be WIDTH bits, unsigned, no overflow for any N up to 2^WIDTH-1.
REQ-027 All outputs registered; no combinational path input->output.

Reset
REQ-028 rst asserted: immediately state IDLE, cnt=0, clk_out=0, rise_tick=0, fall_tick=0, div_ack=0, div_err=0, pending_valid=0, cur_div=DEFAULT_DIV.
REQ-029 rst mid-period SHALL abort the period; after release, block behaves as REQ-016 from IDLE.

Structure
REQ-030 Shared package clkdiv_pkg SHALL hold the state enum and constant DIV_MIN = 2.
REQ-031 One sub-module clkdiv_phase_counter (cnt, wrap flag, high-phase compare) SHALL be instantiated; FSM and divisor load logic stay in the top.

Verification
REQ-032 Reset, DEFAULT_DIV=4, en=1 held: clk_out 1100 repeating, rise_tick every 4 cycles, first rise one cycle after en.
REQ-033 Load div_in=5 mid-period: div_ack next cycle; current 4-cycle period completes, then 11100 repeating, cur_div=5 at that boundary.
REQ-034 Load div_in=1 and div_in=0: div_err each, cur_div unchanged, waveform undisturbed.
REQ-035 N=3, drop en at cnt=0: period completes (110), then IDLE, clk_out stays 0, no ticks; reassert en -> rise one cycle later.
REQ-036 Loads 6 then 9 in consecutive cycles within one period: two acks, next period uses 9 (high 5, low 4).
REQ-037 Assert rst while clk_out=1 at N=8: clk_out 0 immediately, cur_div=DEFAULT_DIV, restart clean on release with en=1.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared state encoding and constants for the programmable clock divider
//
// Purpose: common definitions imported by prog_clock_divider and clkdiv_phase_counter.
// Ports:   none (package).

package clkdiv_pkg;

  // Divider control states: IDLE holds clk_out low, RUN generates periods.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } clkdiv_state_e;

  // Smallest divisor that still yields distinct high and low phases.
  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clkdiv_phase_counter.sv
// rtl/clkdiv_phase_counter.sv - phase counter with period-end flag and high-phase compare
//
// Purpose: counts 0..N-1 while advancing, reports the last cycle of a period and
//          whether the next count still falls inside the high phase.
// Ports:
//   clk_in       - clock, rising edge
//   rst          - asynchronous active-high reset
//   i_clear      - hold the count at zero
//   i_advance    - step the count (wraps to zero after N-1)
//   i_div        - divisor N currently in force (>= 2)
//   o_wrap       - count equals N-1 (period end)
//   o_next_high  - count+1 is below the high-phase length ceil(N/2)

module clkdiv_phase_counter
  import clkdiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_wrap,
  output logic             o_next_high
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_last;
  logic [WIDTH-1:0] w_high;
  logic [WIDTH-1:0] w_next;

  assign w_last = i_div - WIDTH'(1);
  // ceil(N/2) computed as N - floor(N/2) so it never overflows WIDTH bits.
  assign w_high = i_div - (i_div >> 1);
  // Only consumed when r_cnt < N-1, so r_cnt+1 always fits.
  assign w_next = r_cnt + WIDTH'(1);

  assign o_wrap      = (r_cnt == w_last);
  assign o_next_high = (w_next < w_high);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_advance) begin
      r_cnt <= o_wrap ? '0 : w_next;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - programmable integer clock divider with glitch-free divisor updates
//
// Purpose: produces a registered clk_out of period N clk_in cycles (high ceil(N/2)),
//          with edge ticks and a divisor that only changes at period boundaries.
// Ports:
//   clk_in     - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - run request, sampled in IDLE and at period end
//   div_in     - requested divisor N
//   div_load   - one-cycle strobe capturing div_in
//   div_ack    - pulse: load accepted
//   div_err    - pulse: load rejected (div_in < 2)
//   clk_out    - divided clock
//   rise_tick  - high in the cycle clk_out went 0->1
//   fall_tick  - high in the cycle clk_out went 1->0
//   cur_div    - divisor currently in force

module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [WIDTH-1:0] cur_div
);

  clkdiv_state_e    r_state;
  logic             r_clk_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_ack;
  logic             r_err;
  logic             r_pend_valid;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_cur_div;

  logic             w_wrap;
  logic             w_next_high;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_idle;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_load_ok  = div_load && (div_in >= WIDTH'(DIV_MIN));
  assign w_load_bad = div_load && (div_in <  WIDTH'(DIV_MIN));

  clkdiv_phase_counter #(
    .WIDTH (WIDTH)
  ) u_phase (
    .clk_in      (clk_in),
    .rst         (rst),
    .i_clear     (w_idle),
    .i_advance   (!w_idle),
    .i_div       (r_cur_div),
    .o_wrap      (w_wrap),
    .o_next_high (w_next_high)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_clk_out    <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pending    <= '0;
      r_cur_div    <= WIDTH'(DEFAULT_DIV);
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_ack  <= w_load_ok;
      r_err  <= w_load_bad;

      case (r_state)
        ST_IDLE: begin
          r_clk_out <= 1'b0;
          if (en) begin
            r_state   <= ST_RUN;
            r_clk_out <= 1'b1;
            r_rise    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_wrap) begin
            // Period boundary: the only point where the divisor may change.
            if (r_pend_valid) begin
              r_cur_div    <= r_pending;
              r_pend_valid <= 1'b0;
            end
            // clk_out is always low on the last cycle (low phase >= 1).
            if (en) begin
              r_clk_out <= 1'b1;
              r_rise    <= 1'b1;
            end else begin
              r_state   <= ST_IDLE;
              r_clk_out <= 1'b0;
            end
          end else begin
            r_clk_out <= w_next_high;
            r_fall    <= r_clk_out && !w_next_high;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_clk_out <= 1'b0;
        end
      endcase

      // Placed after the period-end handling so a load on the boundary
      // edge lands in pending while the older pending value applies now.
      if (w_load_ok) begin
        if (w_idle && !en) begin
          r_cur_div <= div_in;
        end else begin
          r_pending    <= div_in;
          r_pend_valid <= 1'b1;
        end
      end
    end
  end

  assign div_ack   = r_ack;
  assign div_err   = r_err;
  assign clk_out   = r_clk_out;
  assign rise_tick = r_rise;
  assign fall_tick = r_fall;
  assign cur_div   = r_cur_div;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider

module tb_prog_clock_divider;

  localparam int W = 16;

  // flag field = {clk_out, rise_tick, fall_tick, div_ack, div_err}
  localparam logic [4:0] L = 5'b00000;
  localparam logic [4:0] H = 5'b10000;
  localparam logic [4:0] R = 5'b11000;
  localparam logic [4:0] F = 5'b00100;
  localparam logic [4:0] A = 5'b00010;
  localparam logic [4:0] E = 5'b00001;

  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] din;
    logic [4:0]   flags;
    logic [W-1:0] cur;
  } vec_t;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_ack;
  logic         div_err;
  logic         clk_out;
  logic         rise_tick;
  logic         fall_tick;
  logic [W-1:0] cur_div;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t exp_v;

  always #5 clk_in = ~clk_in;

  prog_clock_divider #(
    .WIDTH       (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .div_ack   (div_ack),
    .div_err   (div_err),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .cur_div   (cur_div)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(input int n, input logic e, input logic l, input int d,
                     input logic [4:0] f, input int c);
    vec_t v;
    v.en = e; v.ld = l; v.din = W'(d); v.flags = f; v.cur = W'(c);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  function automatic logic [31:0] flags_now();
    return {27'b0, clk_out, rise_tick, fall_tick, div_ack, div_err};
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;

    // Default divisor 4 with en held: 1100 repeating, first rise one cycle after en.
    add(1, 1, 0, 0, R, 4); add(1, 1, 0, 0, H, 4); add(1, 1, 0, 0, F, 4); add(1, 1, 0, 0, L, 4);
    add(1, 1, 0, 0, R, 4);
    // Load 5 mid-period: ack next cycle, current period finishes, then 11100.
    add(1, 1, 1, 5, H | A, 4); add(1, 1, 0, 0, F, 4); add(1, 1, 0, 0, L, 4);
    add(1, 1, 0, 0, R, 5); add(2, 1, 0, 0, H, 5); add(1, 1, 0, 0, F, 5); add(1, 1, 0, 0, L, 5);
    add(1, 1, 0, 0, R, 5);
    // Rejected loads of 1 and 0: errors, waveform and divisor undisturbed.
    add(1, 1, 1, 1, H | E, 5); add(1, 1, 1, 0, H | E, 5); add(1, 1, 0, 0, F, 5);
    add(1, 1, 0, 0, L, 5); add(1, 1, 0, 0, R, 5);
    // Loads 6 then 9 back to back: both acked, 9 wins (high 5, low 4).
    add(1, 1, 1, 6, H | A, 5); add(1, 1, 1, 9, H | A, 5); add(1, 1, 0, 0, F, 5);
    add(1, 1, 0, 0, L, 5); add(1, 1, 0, 0, R, 9); add(4, 1, 0, 0, H, 9); add(1, 1, 0, 0, F, 9);
    add(3, 1, 0, 0, L, 9); add(1, 1, 0, 0, R, 9);
    // Switch to 3, then drop en at cnt=0: 110 completes, IDLE stays low.
    add(1, 1, 1, 3, H | A, 9); add(3, 1, 0, 0, H, 9); add(1, 1, 0, 0, F, 9);
    add(3, 1, 0, 0, L, 9); add(1, 1, 0, 0, R, 3);
    add(1, 0, 0, 0, H, 3); add(1, 0, 0, 0, F, 3); add(1, 0, 0, 0, L, 3);
    // Load in IDLE applies on the next edge.
    add(1, 0, 1, 8, L | A, 8); add(1, 0, 0, 0, L, 8);
    // Load with the start edge: first period still uses 8, then 3.
    add(1, 1, 1, 3, R | A, 8); add(3, 1, 0, 0, H, 8); add(1, 1, 0, 0, F, 8);
    add(3, 1, 0, 0, L, 8);
    // Load on the period-end edge: old pending (3) applies now, 4 next.
    add(1, 1, 1, 4, R | A, 3); add(1, 1, 0, 0, H, 3); add(1, 1, 0, 0, F, 3);
    add(1, 1, 0, 0, R, 4);
    // Move to N=8 for the reset-abort sequence.
    add(1, 1, 1, 8, H | A, 4); add(1, 1, 0, 0, F, 4); add(1, 1, 0, 0, L, 4);
    add(1, 1, 0, 0, R, 8); add(1, 1, 0, 0, H, 8);

    // Reset state, with en asserted to confirm it is ignored during reset.
    en = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_flags", flags_now(), 32'h0);
    check("reset_cur_div", 32'(cur_div), 32'd4);
    en = 1'b0;
    rst = 1'b0;
    @(posedge clk_in); @(negedge clk_in);
    check("idle_after_reset", flags_now(), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      en       = vecs[i].en;
      div_load = vecs[i].ld;
      div_in   = vecs[i].din;
      exp_q.push_back(vecs[i]);
      @(posedge clk_in); @(negedge clk_in);
      exp_v = exp_q.pop_front();
      check($sformatf("v%0d_flags", i), flags_now(), 32'(exp_v.flags));
      check($sformatf("v%0d_cur_div", i), 32'(cur_div), 32'(exp_v.cur));
    end
    div_load = 1'b0;

    // Asynchronous reset while clk_out is high at N=8.
    check("pre_rst_clk_high", 32'(clk_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clk_out", 32'(clk_out), 32'd0);
    check("rst_async_cur_div", 32'(cur_div), 32'd4);
    check("rst_async_flags", flags_now(), 32'h0);
    @(posedge clk_in); @(negedge clk_in);
    check("rst_held_flags", flags_now(), 32'h0);
    rst = 1'b0;
    @(posedge clk_in); @(negedge clk_in);
    check("restart_rise", flags_now(), 32'(R));
    check("restart_cur_div", 32'(cur_div), 32'd4);
    @(posedge clk_in); @(negedge clk_in);
    check("restart_high", flags_now(), 32'(H));
    @(posedge clk_in); @(negedge clk_in);
    check("restart_fall", flags_now(), 32'(F));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
